muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over XLEN cycles on operand magnitudes, followed by a sign-fix cycle.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter int ENABLE_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  srca,
    input  logic [XLEN-1:0]  srcb,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic [XLEN-1:0]     b_mag;
    logic [2*XLEN-1:0]   acc;
    logic [CNT_W-1:0]    cnt;
    logic [TAG_W-1:0]    tag_q;

    assign busy = (state != IDLE);

    // Operand decode at accept: signedness per op, magnitudes and sign bits.
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sign_a   = a_signed & srca[XLEN-1];
        sign_b   = b_signed & srcb[XLEN-1];
        mag_a    = sign_a ? -srca : srca;
        mag_b    = sign_b ? -srcb : srcb;
    end

    // Divide corner cases resolved at accept without iterating.
    logic            special, special_ill;
    logic [XLEN-1:0] special_val;

    always_comb begin
        special     = 1'b0;
        special_ill = 1'b0;
        special_val = '0;
        if (op[2]) begin
            if (ENABLE_DIV == 0) begin
                special     = 1'b1;
                special_ill = 1'b1;
            end else if (srcb == '0) begin
                special     = 1'b1;
                special_val = op[1] ? srca : '1;
            end else if (!op[0] && srca == MOST_NEG && (&srcb)) begin
                special     = 1'b1;
                special_val = op[1] ? '0 : srca;
            end
        end
    end

    // One iteration step; the accumulator holds {partial, multiplier} for
    // multiply and {remainder, dividend/quotient} for divide.
    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] step_acc;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
        rem_shift = acc[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, b_mag};
        q_bit     = (rem_shift >= {1'b0, b_mag});
        if (ENABLE_DIV != 0 && op_q[2])
            step_acc = {(q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0]), acc[XLEN-2:0], q_bit};
        else
            step_acc = {mul_sum, acc[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_val;

    always_comb begin
        prod = (sign_a_q ^ sign_b_q) ? -acc : acc;
        quo  = (sign_a_q ^ sign_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_val = quo;
            default:                     fix_val = rem;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and the async
    // reset clears the datapath registers too, not just the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_mag    <= '0;
            acc      <= '0;
            cnt      <= '0;
            tag_q    <= '0;
            result   <= '0;
            tag_out  <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        op_q     <= op;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        b_mag    <= mag_b;
                        acc      <= {{XLEN{1'b0}}, mag_a};
                        cnt      <= '0;
                        tag_q    <= tag_in;
                        if (special) begin
                            result  <= special_val;
                            tag_out <= tag_in;
                            done    <= 1'b1;
                            illegal <= special_ill;
                            state   <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc <= step_acc;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_STEP) state <= FIX;
                    end
                    FIX: begin
                        result  <= fix_val;
                        tag_out <= tag_q;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, special cases,
// flush/reset aborts, and a divider-less instance; expectations via a scoreboard queue.
module tb_muldiv_unit;

    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] srca, srcb;
    logic [4:0]  tag_in;

    logic        d_busy, d_done, d_ill;
    logic [31:0] d_res;
    logic [4:0]  d_tag;
    logic        n_busy, n_done, n_ill;
    logic [31:0] n_res;
    logic [4:0]  n_tag;

    logic        use_nd = 1'b0;
    logic        m_busy, m_done, m_ill;
    logic [31:0] m_res;
    logic [4:0]  m_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    muldiv_unit #(.XLEN(32), .TAG_W(5), .ENABLE_DIV(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .tag_in(tag_in), .flush(flush), .busy(d_busy), .done(d_done), .result(d_res),
        .tag_out(d_tag), .illegal(d_ill)
    );

    muldiv_unit #(.XLEN(32), .TAG_W(5), .ENABLE_DIV(0)) dut_nodiv (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .tag_in(tag_in), .flush(flush), .busy(n_busy), .done(n_done), .result(n_res),
        .tag_out(n_tag), .illegal(n_ill)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_busy = use_nd ? n_busy : d_busy;
        m_done = use_nd ? n_done : d_done;
        m_ill  = use_nd ? n_ill  : d_ill;
        m_res  = use_nd ? n_res  : d_res;
        m_tag  = use_nd ? n_tag  : d_tag;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference behaviour from the RV32M definition using wide signed arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'b0, b})); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == MOST_NEG && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == MOST_NEG && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_cycles(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0 || (!o[0] && a == MOST_NEG && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    // Issue one op, push its expectation, then wait (bounded) for done and compare.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp_res,
                          input logic exp_ill, input int exp_cyc);
        exp_t e;
        int   cyc = 0;
        int   busy_cnt = 0;
        logic seen = 1'b0;
        exp_q.push_back('{exp_res, t, exp_ill, exp_cyc});
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b; tag_in = t;
        @(posedge clk);
        #1;
        start = 1'b0; srca = $urandom; srcb = $urandom; tag_in = 5'($urandom);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (m_busy) busy_cnt++;
            if (m_done) seen = 1'b1;
        end
        check({name, " done_seen"}, 64'(seen), 64'(1));
        if (seen) begin
            e = exp_q.pop_front();
            check({name, " latency"}, 64'(cyc), 64'(e.cyc));
            check({name, " result"}, 64'(m_res), 64'(e.res));
            check({name, " tag_out"}, 64'(m_tag), 64'(e.tag));
            check({name, " illegal"}, 64'(m_ill), 64'(e.ill));
            check({name, " busy_cycles"}, 64'(busy_cnt), 64'(e.cyc));
            @(negedge clk);
            check({name, " idle_after"}, 64'(m_busy), 64'(0));
            check({name, " done_pulse"}, 64'(m_done), 64'(0));
        end else begin
            exp_q.delete();
        end
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        logic got = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (d_done) got = 1'b1;
        end
        check({name, " no_done"}, 64'(got), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
        srca = '0; srcb = '0; tag_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(d_busy), 64'(0));
        check("reset done", 64'(d_done), 64'(0));
        check("reset result", 64'(d_res), 64'(0));
        check("reset tag_out", 64'(d_tag), 64'(0));
        check("reset illegal", 64'(d_ill), 64'(0));
        reset = 1'b0;

        run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 34);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0, 34);
        run_op("mulh_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b0, 34);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("divu_big/2", 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, 1'b0, 34);

        run_op("div_by_zero", 3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("remu_by_zero", 3'd7, 32'd5, 32'd0, 5'd9, 32'd5, 1'b0, 1);
        run_op("rem_overflow", 3'd6, MOST_NEG, 32'hFFFF_FFFF, 5'd10, 32'd0, 1'b0, 1);
        run_op("div_overflow", 3'd4, MOST_NEG, 32'hFFFF_FFFF, 5'd11, MOST_NEG, 1'b0, 1);

        // flush wins over start in the same idle cycle
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; srca = 32'd2; srcb = 32'd2; tag_in = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start busy", 64'(d_busy), 64'(0));

        // abort an in-flight divide
        @(negedge clk);
        start = 1'b1; op = 3'd4; srca = 32'd100; srcb = 32'd7; tag_in = 5'd21;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(d_busy), 64'(0));
        expect_no_done("abort", 40);
        check("abort result_kept", 64'(d_res), 64'(MOST_NEG));
        check("abort tag_kept", 64'(d_tag), 64'(11));
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 1'b0, 34);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (ro[2] && (i % 2 == 1)) rb = 32'($urandom_range(1, 50));
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 5'(i + 13),
                   ref_model(ro, ra, rb), 1'b0, exp_cycles(ro, ra, rb));
        end

        // reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 3'd0; srca = 32'd9; srcb = 32'd9; tag_in = 5'd30;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset busy", 64'(d_busy), 64'(0));
        check("midreset done", 64'(d_done), 64'(0));
        check("midreset result", 64'(d_res), 64'(0));
        check("midreset tag_out", 64'(d_tag), 64'(0));
        check("midreset illegal", 64'(d_ill), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_no_done("midreset", 40);
        run_op("mul_after_reset", 3'd0, 32'd6, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFA, 1'b0, 34);

        // divider-less instance flags divide ops as illegal
        use_nd = 1'b1;
        run_op("nodiv_divu", 3'd5, 32'd8, 32'd2, 5'd17, 32'd0, 1'b1, 1);
        use_nd = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
